// File: rtl/stream_pool2x2_pkg.sv
// Shared constants and helpers for the streaming 2x2 pooler.
// Build option: AVG_ROUND_EN widens the accumulator by one guard bit so the
// round-half-up bias can be added without overflow.
package stream_pool2x2_pkg;

    localparam int MODE_AVG = 0;
    localparam int MODE_MAX = 1;

    // Width of the vertical (final) combine result for a given sample width.
    function automatic int acc_width(input int data_width);
`ifdef AVG_ROUND_EN
        return data_width + 3;
`else
        return data_width + 2;
`endif
    endfunction

endpackage

// File: rtl/stream_pool2x2_combine.sv
// Per-channel combine of two signed operands: sign-extended sum (average
// mode) or signed maximum (max mode), widened to OUT_W bits.
module pool_combine
    import stream_pool2x2_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 17,
    parameter int MODE  = MODE_AVG
) (
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  b_i,
    output logic signed [OUT_W-1:0] y_o
);

    localparam int EXT_W = OUT_W - IN_W;

    if (EXT_W < 1) begin : g_bad_width
        $error("pool_combine: OUT_W must exceed IN_W");
    end

    if (MODE == MODE_MAX) begin : g_max
        logic signed [IN_W-1:0] max_s;
        assign max_s = (a_i > b_i) ? a_i : b_i;
        assign y_o   = {{EXT_W{max_s[IN_W-1]}}, max_s};
    end else begin : g_avg
        assign y_o = {{EXT_W{a_i[IN_W-1]}}, a_i} + {{EXT_W{b_i[IN_W-1]}}, b_i};
    end

endmodule

// File: rtl/stream_pool2x2.sv
// Streaming 2x2 / stride-2 pooling (average or max) over a raster-order
// pixel stream, Depth channels per beat. A half-width line buffer holds the
// horizontal pair results of each even row until the odd row completes them.
// Build option: AVG_ROUND_EN selects round-half-up instead of floor in
// average mode.
module stream_pool2x2
    import stream_pool2x2_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int InputH     = 28,
    parameter int InputW     = 28,
    parameter int Depth      = 1,
    parameter int MODE       = MODE_AVG
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [Depth*DATA_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [Depth*DATA_WIDTH-1:0]   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last
);

    localparam int H_W      = DATA_WIDTH + 1;
    localparam int ACC_W    = acc_width(DATA_WIDTH);
    localparam int COL_W    = (InputW > 1) ? $clog2(InputW) : 1;
    localparam int ROW_W    = (InputH > 1) ? $clog2(InputH) : 1;
    localparam int LB_DEPTH = InputW / 2;
    localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(InputW - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(InputH - 1);

    if ((InputH % 2) != 0 || (InputW % 2) != 0 || InputH < 2 || InputW < 2) begin : g_bad_frame
        $error("stream_pool2x2: InputH and InputW must be even and >= 2");
    end

    logic [COL_W-1:0]               col_q, col_d;
    logic [ROW_W-1:0]               row_q, row_d;
    logic [Depth*DATA_WIDTH-1:0]    hold_q, hold_d;
    logic [Depth*DATA_WIDTH-1:0]    out_data_q, out_data_d;
    logic                           out_valid_q, out_valid_d;
    logic                           out_last_q, out_last_d;
    logic [Depth*H_W-1:0]           linebuf_q [LB_DEPTH];
    logic                           lb_we_s;
    logic [LB_AW-1:0]               lb_idx_s;
    logic [Depth*H_W-1:0]           lb_rd_s;
    logic [Depth*H_W-1:0]           h_s;
    logic [Depth*DATA_WIDTH-1:0]    res_s;
    logic                           accept_s;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept_s  = in_valid & in_ready;
    assign lb_idx_s  = LB_AW'(col_q >> 1);
    assign lb_rd_s   = linebuf_q[lb_idx_s];

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

    // Per-channel datapath: horizontal pair, vertical combine, final scaling.
    for (genvar c = 0; c < Depth; c++) begin : g_ch
        logic signed [H_W-1:0]   h_ch_s;
        logic signed [ACC_W-1:0] v_ch_s;

        pool_combine #(
            .IN_W  (DATA_WIDTH),
            .OUT_W (H_W),
            .MODE  (MODE)
        ) u_h (
            .a_i (hold_q[c*DATA_WIDTH +: DATA_WIDTH]),
            .b_i (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .y_o (h_ch_s)
        );

        pool_combine #(
            .IN_W  (H_W),
            .OUT_W (ACC_W),
            .MODE  (MODE)
        ) u_v (
            .a_i (lb_rd_s[c*H_W +: H_W]),
            .b_i (h_ch_s),
            .y_o (v_ch_s)
        );

        assign h_s[c*H_W +: H_W] = h_ch_s;

        if (MODE == MODE_MAX) begin : g_max_res
            // The max of inputs is an exact input value, so truncation is lossless.
            assign res_s[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v_ch_s);
        end else begin : g_avg_res
            logic signed [ACC_W-1:0] sum_s;
`ifdef AVG_ROUND_EN
            assign sum_s = v_ch_s + ACC_W'(2);
`else
            assign sum_s = v_ch_s;
`endif
            // Divide by four with floor; the quotient always fits DATA_WIDTH.
            assign res_s[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sum_s >>> 2);
        end
    end

    // Next-state logic: raster counters, hold register, line-buffer write, output load/drain.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        lb_we_s     = 1'b0;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (accept_s) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
            end

            if (!col_q[0]) begin
                hold_d = in_data;
            end else if (!row_q[0]) begin
                lb_we_s = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = res_s;
                out_last_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end else begin
            col_d = col_q;
        end
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (lb_we_s) begin
            linebuf_q[lb_idx_s] <= h_s;
        end
    end

endmodule
